// File: rtl/maze_gen_pkg.sv
// Shared constants, encodings and helpers for the maze generator.
// Grid geometry is fixed at 40x30; each difficulty level uses a top-left sub-grid of it.
package maze_pkg;

    localparam int MAP_W    = 40;
    localparam int MAP_H    = 30;
    localparam int MAP_BITS = MAP_W * MAP_H;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    localparam logic [10:0] ENTRANCE_IDX      = 11'd40;

    typedef enum logic [1:0] {
        LVL_EASY     = 2'b00,
        LVL_NORMAL   = 2'b01,
        LVL_HARD     = 2'b10,
        LVL_HARD_ALT = 2'b11
    } level_t;

    localparam logic [5:0] EASY_W   = 6'd16;
    localparam logic [4:0] EASY_H   = 5'd12;
    localparam logic [5:0] NORMAL_W = 6'd32;
    localparam logic [4:0] NORMAL_H = 5'd24;
    localparam logic [5:0] HARD_W   = 6'd40;
    localparam logic [4:0] HARD_H   = 5'd30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CARVE,
        ST_OPEN,
        ST_DONE
    } state_t;

    function automatic logic [5:0] level_w(input logic [1:0] lvl);
        case (lvl)
            LVL_EASY:   return EASY_W;
            LVL_NORMAL: return NORMAL_W;
            default:    return HARD_W;
        endcase
    endfunction

    function automatic logic [4:0] level_h(input logic [1:0] lvl);
        case (lvl)
            LVL_EASY:   return EASY_H;
            LVL_NORMAL: return NORMAL_H;
            default:    return HARD_H;
        endcase
    endfunction

endpackage

// File: rtl/maze_gen_if.sv
// Control/map bus between the game-control FSM (master), the maze generator (slave)
// and the draw block, which reads the map and status lines.
interface maze_gen_if;
    import maze_pkg::*;

    logic                i_Start;
    logic [1:0]          i_MazeLevel;
    logic [15:0]         i_Seed;
    logic [MAP_BITS-1:0] o_MazeMap;
    logic                o_MapValid;
    logic                o_Busy;
    logic                o_Done;

    modport master (
        output i_Start, i_MazeLevel, i_Seed,
        input  o_MazeMap, o_MapValid, o_Busy, o_Done
    );

    modport slave (
        input  i_Start, i_MazeLevel, i_Seed,
        output o_MazeMap, o_MapValid, o_Busy, o_Done
    );

endinterface

// File: rtl/maze_gen_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting left with feedback into bit 0.
// A zero seed would lock the register, so it is replaced by the default seed on load.
module maze_lfsr
    import maze_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] seed,
    output logic        o_lsb
);

    logic [15:0] q;
    logic        feedback;

    assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];
    assign o_lsb    = q[0];

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            q <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            q <= (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
        end else if (en) begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/maze_gen.sv
// Binary-tree maze generator writing the 40x30 wall bitmap for the draw block.
// Build option MAZE_GEN_FREERUN_EN: LFSR free-runs from reset and i_Seed is ignored.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_IDLE  | map held, waiting for i_Start
//  ST_FILL  | write one grid row per cycle, rows 0..29
//  ST_CARVE | clear one room and one neighbour per cycle
//  ST_OPEN  | clear entrance and exit cells
//  ST_DONE  | raise o_Done / o_MapValid, drop o_Busy
module maze_gen
    import maze_pkg::*;
(
    input  logic      i_Clk,
    input  logic      i_Rst,
    maze_gen_if.slave bus
);

    state_t              state_q;
    state_t              state_d;

    logic [5:0]          w_q;
    logic [4:0]          h_q;
    logic [4:0]          fill_row_q;
    logic [4:0]          room_r_q;
    logic [5:0]          room_c_q;

    logic [MAP_BITS-1:0] map_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic                start_ok;
    logic                last_col;
    logic                last_room;
    logic                carve_north;
    logic                carve_west;
    logic                lfsr_bit;
    logic                lfsr_load;
    logic                lfsr_en;

    logic [10:0]         room_idx;
    logic [10:0]         exit_idx;
    logic [10:0]         fill_base;
    logic [MAP_W-1:0]    fill_bits;

    assign room_idx  = 11'(room_r_q) * 11'(MAP_W) + 11'(room_c_q);
    assign exit_idx  = 11'(h_q - 5'd3) * 11'(MAP_W) + 11'(w_q - 6'd2);
    assign fill_base = 11'(fill_row_q) * 11'(MAP_W);
    assign fill_bits = (fill_row_q < h_q) ? ~({MAP_W{1'b1}} << w_q) : '0;

    assign last_col  = (room_c_q == w_q - 6'd3);
    assign last_room = last_col && (room_r_q == h_q - 5'd3);

`ifdef MAZE_GEN_FREERUN_EN
    assign lfsr_load = 1'b0;
    assign lfsr_en   = 1'b1;
`else
    assign lfsr_load = start_ok;
    assign lfsr_en   = (state_q == ST_CARVE);
`endif

    maze_lfsr u_lfsr (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .seed  (bus.i_Seed),
        .o_lsb (lfsr_bit)
    );

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ok    = 1'b0;
        carve_north = 1'b0;
        carve_west  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    start_ok = 1'b1;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_row_q == 5'(MAP_H - 1)) begin
                    state_d = ST_CARVE;
                end
            end
            ST_CARVE: begin
                // Top row can only go west, left column only north; (1,1) opens neither.
                carve_north = (room_r_q != 5'd1) && ((room_c_q == 6'd1) || lfsr_bit);
                carve_west  = (room_c_q != 6'd1) && ((room_r_q == 5'd1) || !lfsr_bit);
                if (last_room) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            w_q        <= EASY_W;
            h_q        <= EASY_H;
            fill_row_q <= '0;
            room_r_q   <= 5'd1;
            room_c_q   <= 6'd1;
        end else begin
            if (start_ok) begin
                w_q        <= level_w(bus.i_MazeLevel);
                h_q        <= level_h(bus.i_MazeLevel);
                fill_row_q <= '0;
                room_r_q   <= 5'd1;
                room_c_q   <= 6'd1;
            end else if (state_q == ST_FILL) begin
                fill_row_q <= fill_row_q + 5'd1;
            end else if (state_q == ST_CARVE) begin
                if (last_col) begin
                    room_c_q <= 6'd1;
                    room_r_q <= room_r_q + 5'd2;
                end else begin
                    room_c_q <= room_c_q + 6'd2;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            map_q <= '0;
        end else begin
            case (state_q)
                ST_FILL: map_q[fill_base +: MAP_W] <= fill_bits;
                ST_CARVE: begin
                    map_q[room_idx] <= 1'b0;
                    if (carve_north) begin
                        map_q[room_idx - 11'(MAP_W)] <= 1'b0;
                    end
                    if (carve_west) begin
                        map_q[room_idx - 11'd1] <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    map_q[ENTRANCE_IDX]      <= 1'b0;
                    map_q[exit_idx]          <= 1'b0;
                    map_q[exit_idx + 11'd1]  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            if (start_ok) begin
                valid_q <= 1'b0;
                busy_q  <= 1'b1;
            end else if (state_q == ST_DONE) begin
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    assign bus.o_MazeMap  = map_q;
    assign bus.o_MapValid = valid_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Done     = done_q;

endmodule

// File: tb/tb_maze_gen.sv
// Directed bench for maze_gen: latency, map shape, seed behaviour, busy protection, reset.
module tb_maze_gen;
    import maze_pkg::*;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b0;
    always #5 i_Clk = ~i_Clk;

    maze_gen_if bus ();

    maze_gen dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [1199:0] map_a, map_b, map_c, exp_map;
    int            lat;
    logic          st_valid, st_busy, st_done;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference maze straight from the algorithm description.
    function automatic logic [1199:0] model_map(input logic [1:0] lvl, input logic [15:0] seed);
        int w, h;
        logic [15:0] s;
        logic [1199:0] m;
        case (lvl)
            2'b00:   begin w = 16; h = 12; end
            2'b01:   begin w = 32; h = 24; end
            default: begin w = 40; h = 30; end
        endcase
        s = (seed == 16'h0000) ? 16'hACE1 : seed;
        m = '0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                m[r*40+c] = 1'b1;
        for (int r = 1; r <= h - 3; r += 2) begin
            for (int c = 1; c <= w - 3; c += 2) begin
                m[r*40+c] = 1'b0;
                if (r == 1 && c == 1) begin
                end else if (r == 1) m[r*40+c-1] = 1'b0;
                else if (c == 1)     m[(r-1)*40+c] = 1'b0;
                else if (s[0])       m[(r-1)*40+c] = 1'b0;
                else                 m[r*40+c-1] = 1'b0;
                s = lfsr_step(s);
            end
        end
        m[40] = 1'b0;
        m[(h-3)*40+w-2] = 1'b0;
        m[(h-3)*40+w-1] = 1'b0;
        return m;
    endfunction

    function automatic int count_diff(input logic [1199:0] a, input logic [1199:0] b);
        int n = 0;
        for (int i = 0; i < 1200; i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic run_gen(input logic [1:0] lvl, input logic [15:0] seed, input int poke_cyc,
                           input logic [1:0] poke_lvl, input logic [15:0] poke_seed,
                           output int latency, output logic [1199:0] map);
        int cyc;
        @(negedge i_Clk);
        bus.i_Start     = 1'b1;
        bus.i_MazeLevel = lvl;
        bus.i_Seed      = seed;
        @(posedge i_Clk);
        @(negedge i_Clk);
        bus.i_Start = 1'b0;
        st_valid = bus.o_MapValid;
        st_busy  = bus.o_Busy;
        st_done  = bus.o_Done;
        cyc = 0;
        while (bus.o_Done !== 1'b1 && cyc < 1000) begin
            if (cyc == poke_cyc) begin
                bus.i_Start     = 1'b1;
                bus.i_MazeLevel = poke_lvl;
                bus.i_Seed      = poke_seed;
            end
            @(posedge i_Clk);
            cyc++;
            @(negedge i_Clk);
            bus.i_Start = 1'b0;
        end
        latency = cyc;
        map = bus.o_MazeMap;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_Clk);
        n_vec++;
        if (bus.o_MazeMap !== '0 || bus.o_MapValid !== 1'b0 || bus.o_Busy !== 1'b0 || bus.o_Done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b busy=%b done=%b map_ones=%0d expected all zero",
                     bus.o_MapValid, bus.o_Busy, bus.o_Done, count_diff(bus.o_MazeMap, '0));
        end
        i_Rst = 1'b1;
    endtask

    task automatic test_easy();
        int oob, zeros;
        run_gen(2'b00, 16'h0001, -1, 2'b00, 16'h0000, lat, map_a);
        n_vec++;
        if (st_valid !== 1'b0 || st_busy !== 1'b1 || st_done !== 1'b0) begin
            n_err++;
            $display("FAIL easy_start_status: got valid=%b busy=%b done=%b expected 0 1 0", st_valid, st_busy, st_done);
        end
        n_vec++;
        if (lat !== 67) begin n_err++; $display("FAIL easy_latency: got %0d expected 67", lat); end
        n_vec++;
        if (bus.o_MapValid !== 1'b1 || bus.o_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL easy_done_status: got valid=%b busy=%b expected 1 0", bus.o_MapValid, bus.o_Busy);
        end
        exp_map = model_map(2'b00, 16'h0001);
        n_vec++;
        if (map_a !== exp_map) begin n_err++; $display("FAIL easy_map: %0d bits differ from model", count_diff(map_a, exp_map)); end
        oob = 0; zeros = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++) begin
                if ((r >= 12 || c >= 16) && map_a[r*40+c] !== 1'b0) oob++;
                if (r < 12 && c < 16 && map_a[r*40+c] === 1'b0) zeros++;
            end
        n_vec++;
        if (oob !== 0) begin n_err++; $display("FAIL easy_outside_grid: got %0d set bits expected 0", oob); end
        n_vec++;
        if (zeros !== 72) begin n_err++; $display("FAIL easy_open_count: got %0d expected 72", zeros); end
        n_vec++;
        if ({map_a[0], map_a[40], map_a[374], map_a[375]} !== 4'b1000) begin
            n_err++;
            $display("FAIL easy_corner_bits: got b0=%b b40=%b b374=%b b375=%b expected 1 0 0 0",
                     map_a[0], map_a[40], map_a[374], map_a[375]);
        end
        @(negedge i_Clk);
        n_vec++;
        if (bus.o_Done !== 1'b0 || bus.o_MapValid !== 1'b1 || bus.o_MazeMap !== map_a) begin
            n_err++;
            $display("FAIL easy_hold: got done=%b valid=%b expected done 0 valid 1 map held", bus.o_Done, bus.o_MapValid);
        end
    endtask

    task automatic test_hard();
        int bad, zeros, idx;
        run_gen(2'b10, 16'h1234, -1, 2'b00, 16'h0000, lat, map_b);
        n_vec++;
        if (st_valid !== 1'b0 || st_busy !== 1'b1) begin
            n_err++;
            $display("FAIL hard_valid_drop: got valid=%b busy=%b expected 0 1", st_valid, st_busy);
        end
        n_vec++;
        if (lat !== 298) begin n_err++; $display("FAIL hard_latency: got %0d expected 298", lat); end
        exp_map = model_map(2'b10, 16'h1234);
        n_vec++;
        if (map_b !== exp_map) begin n_err++; $display("FAIL hard_map: %0d bits differ from model", count_diff(map_b, exp_map)); end
        bad = 0; zeros = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++) begin
                idx = r * 40 + c;
                if (map_b[idx] === 1'b0) zeros++;
                if ((r == 0 || r == 29 || c == 0 || c == 39) && idx != 40 && idx != 27*40+39) begin
                    if (map_b[idx] !== 1'b1) bad++;
                end
            end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL hard_border: got %0d open border cells expected 0", bad); end
        n_vec++;
        if ({map_b[40], map_b[27*40+38], map_b[27*40+39]} !== 3'b000) begin
            n_err++;
            $display("FAIL hard_openings: got %b expected 000", {map_b[40], map_b[27*40+38], map_b[27*40+39]});
        end
        n_vec++;
        if (zeros !== 534) begin n_err++; $display("FAIL hard_open_count: got %0d expected 534", zeros); end
    endtask

    task automatic test_level3();
        run_gen(2'b11, 16'h1234, -1, 2'b00, 16'h0000, lat, map_c);
        n_vec++;
        if (lat !== 298) begin n_err++; $display("FAIL level3_latency: got %0d expected 298", lat); end
        exp_map = model_map(2'b10, 16'h1234);
        n_vec++;
        if (map_c !== exp_map) begin n_err++; $display("FAIL level3_map: %0d bits differ from hard model", count_diff(map_c, exp_map)); end
    endtask

    task automatic test_seed();
        run_gen(2'b01, 16'h0000, -1, 2'b00, 16'h0000, lat, map_a);
        run_gen(2'b01, 16'hACE1, -1, 2'b00, 16'h0000, lat, map_b);
        exp_map = model_map(2'b01, 16'hACE1);
        n_vec++;
        if (map_a !== exp_map) begin n_err++; $display("FAIL seed_zero_map: %0d bits differ from model", count_diff(map_a, exp_map)); end
        n_vec++;
        if (map_a !== map_b) begin n_err++; $display("FAIL seed_zero_vs_default: %0d bits differ, expected 0", count_diff(map_a, map_b)); end
        run_gen(2'b01, 16'h5A5A, -1, 2'b00, 16'h0000, lat, map_c);
        exp_map = model_map(2'b01, 16'h5A5A);
        n_vec++;
        if (map_c !== exp_map) begin n_err++; $display("FAIL seed_5a5a_map: %0d bits differ from model", count_diff(map_c, exp_map)); end
        n_vec++;
        if (map_c === map_b) begin n_err++; $display("FAIL seed_distinct: got 0 differing bits expected nonzero"); end
    endtask

    task automatic test_busy_ignore();
        int oob;
        run_gen(2'b01, 16'h0BEE, 50, 2'b00, 16'hFFFF, lat, map_a);
        n_vec++;
        if (lat !== 197) begin n_err++; $display("FAIL busy_latency: got %0d expected 197", lat); end
        exp_map = model_map(2'b01, 16'h0BEE);
        n_vec++;
        if (map_a !== exp_map) begin n_err++; $display("FAIL busy_map: %0d bits differ from normal model", count_diff(map_a, exp_map)); end
        oob = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                if ((r >= 24 || c >= 32) && map_a[r*40+c] !== 1'b0) oob++;
        n_vec++;
        if (oob !== 0) begin n_err++; $display("FAIL busy_dims: got %0d set bits outside 32x24 expected 0", oob); end
        repeat (3) @(negedge i_Clk);
        n_vec++;
        if (bus.o_Busy !== 1'b0 || bus.o_MapValid !== 1'b1) begin
            n_err++;
            $display("FAIL busy_no_restart: got busy=%b valid=%b expected 0 1", bus.o_Busy, bus.o_MapValid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge i_Clk);
        bus.i_Start     = 1'b1;
        bus.i_MazeLevel = 2'b10;
        bus.i_Seed      = 16'h7777;
        @(negedge i_Clk);
        bus.i_Start = 1'b0;
        repeat (100) @(negedge i_Clk);
        n_vec++;
        if (bus.o_Busy !== 1'b1) begin n_err++; $display("FAIL midreset_pre_busy: got %b expected 1", bus.o_Busy); end
        #2 i_Rst = 1'b0;
        #1;
        n_vec++;
        if (bus.o_MazeMap !== '0 || bus.o_MapValid !== 1'b0 || bus.o_Busy !== 1'b0 || bus.o_Done !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_async: got valid=%b busy=%b done=%b map_ones=%0d expected all zero",
                     bus.o_MapValid, bus.o_Busy, bus.o_Done, count_diff(bus.o_MazeMap, '0));
        end
        @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (5) @(negedge i_Clk);
        n_vec++;
        if (bus.o_Busy !== 1'b0 || bus.o_MapValid !== 1'b0 || bus.o_MazeMap !== '0) begin
            n_err++;
            $display("FAIL midreset_idle: got busy=%b valid=%b expected 0 0 and empty map", bus.o_Busy, bus.o_MapValid);
        end
        run_gen(2'b00, 16'h0001, -1, 2'b00, 16'h0000, lat, map_a);
        exp_map = model_map(2'b00, 16'h0001);
        n_vec++;
        if (lat !== 67 || map_a !== exp_map) begin
            n_err++;
            $display("FAIL midreset_restart: got latency %0d diff %0d expected 67 and 0", lat, count_diff(map_a, exp_map));
        end
    endtask

    initial begin
        bus.i_Start     = 1'b0;
        bus.i_MazeLevel = 2'b00;
        bus.i_Seed      = 16'h0000;
        i_Rst           = 1'b0;
        test_reset();
        test_easy();
        test_hard();
        test_level3();
        test_seed();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
